// File: rtl/bcd_sub8_if.sv
// bcd_sub8 request/result bundle.
// The master drives the operands and start; the slave returns status and result.
interface bcd_sub8_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       neg;
  logic       invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, invalid
  );
endinterface

// File: rtl/bcd_sub8.sv
// Digit-serial two-digit packed BCD subtractor.
// Negative results get a second ten's-complement pass to sign-magnitude.
module bcd_sub8 (
  input  logic       clk,
  input  logic       rst,
  bcd_sub8_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SUB0 = 3'd1;
  localparam logic [2:0] SUB1 = 3'd2;
  localparam logic [2:0] NEG0 = 3'd3;
  localparam logic [2:0] NEG1 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0] state;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] diff_q;
  logic       borrow;
  logic       neg_q;
  logic       inv_q;

  logic [3:0] x;
  logic [3:0] y;
  logic       bin;
  logic [3:0] dig;
  logic       bout;
  logic       accept;
  logic       bad;

  // Returns {borrow_out, digit} for one decimal digit of x - y - bin.
  function automatic logic [4:0] dstep(
    input logic [3:0] xa,
    input logic [3:0] ya,
    input logic       bi
  );
    logic [4:0] t;
    logic [4:0] s;
    t = {1'b0, xa} - {1'b0, ya} - {4'b0, bi};
    s = t + 5'd10;
    if (t[4]) return {1'b1, s[3:0]};
    return {1'b0, t[3:0]};
  endfunction

  always_comb begin
    x   = ra[3:0];
    y   = rb[3:0];
    bin = 1'b0;
    unique case (state)
      SUB1: begin
        x   = ra[7:4];
        y   = rb[7:4];
        bin = borrow;
      end
      NEG0: begin
        x   = 4'd0;
        y   = diff_q[3:0];
        bin = 1'b0;
      end
      NEG1: begin
        x   = 4'd0;
        y   = diff_q[7:4];
        bin = borrow;
      end
      default: begin
        x   = ra[3:0];
        y   = rb[3:0];
        bin = 1'b0;
      end
    endcase
  end

  assign {bout, dig} = dstep(x, y, bin);

  assign accept = bus.start && (state == IDLE || state == DONE);

  assign bad = (bus.a[3:0] > 4'd9) || (bus.a[7:4] > 4'd9) ||
               (bus.b[3:0] > 4'd9) || (bus.b[7:4] > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= 8'h00;
      rb     <= 8'h00;
      diff_q <= 8'h00;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      inv_q  <= 1'b0;
    end else if (accept) begin
      ra     <= bus.a;
      rb     <= bus.b;
      diff_q <= 8'h00;
      borrow <= 1'b0;
      neg_q  <= 1'b0;
      inv_q  <= bad;
      state  <= bad ? DONE : SUB0;
    end else begin
      case (state)
        SUB0: begin
          diff_q[3:0] <= dig;
          borrow      <= bout;
          state       <= SUB1;
        end
        SUB1: begin
          diff_q[7:4] <= dig;
          borrow      <= bout;
          state       <= bout ? NEG0 : DONE;
        end
        NEG0: begin
          diff_q[3:0] <= dig;
          borrow      <= bout;
          state       <= NEG1;
        end
        // 100 - raw is the magnitude; the final borrow carries no information.
        NEG1: begin
          diff_q[7:4] <= dig;
          borrow      <= 1'b0;
          neg_q       <= 1'b1;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == SUB0) || (state == SUB1) ||
                       (state == NEG0) || (state == NEG1);
  assign bus.done    = (state == DONE);
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = inv_q;

endmodule

// File: tb/tb_bcd_sub8.sv
// Vector-table and scoreboard bench for bcd_sub8.
// Expected results are queued at drive time and checked on done.
module tb_bcd_sub8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       neg;
    logic       inv;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       neg;
    logic       inv;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];
  vec_t tv[11];

  bcd_sub8_if ifc();

  bcd_sub8 dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic n,
                      input logic iv, input int c);
    exp_t e;
    e.diff = d;
    e.neg  = n;
    e.inv  = iv;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (!rst && ifc.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, want 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("diff", 32'(ifc.diff), 32'(e.diff));
        chk("neg", 32'(ifc.neg), 32'(e.neg));
        chk("invalid", 32'(ifc.invalid), 32'(e.inv));
      end
    end
  endtask

  task automatic wait_empty(input int maxc);
    for (int k = 0; k < maxc && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply(input vec_t v);
    int bc;
    bc = 0;
    @(negedge clk);
    #1;
    ifc.a     = v.a;
    ifc.b     = v.b;
    ifc.start = 1'b1;
    push(v.diff, v.neg, v.inv, cyc + v.lat);
    for (int k = 0; k < 12 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
      ifc.start = 1'b0;
      if (ifc.busy) bc++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout a=%h b=%h: no done, want done", v.a, v.b);
      sb.delete();
    end else begin
      chk("busy_cycles", 32'(bc), 32'(v.lat > 1 ? v.lat - 1 : 0));
      @(negedge clk);
      #1;
      chk("hold_done", 32'(ifc.done), 32'd0);
      chk("hold_diff", 32'(ifc.diff), 32'(v.diff));
      chk("hold_neg", 32'(ifc.neg), 32'(v.neg));
      chk("hold_inv", 32'(ifc.invalid), 32'(v.inv));
    end
  endtask

  initial begin
    vec_t v;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = 8'h00;
    ifc.b     = 8'h00;

    tv[0]  = '{8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 3};
    tv[1]  = '{8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 5};
    tv[2]  = '{8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 5};
    tv[3]  = '{8'h50, 8'h51, 8'h01, 1'b1, 1'b0, 5};
    tv[4]  = '{8'h50, 8'h50, 8'h00, 1'b0, 1'b0, 3};
    tv[5]  = '{8'h99, 8'h00, 8'h99, 1'b0, 1'b0, 3};
    tv[6]  = '{8'h30, 8'h01, 8'h29, 1'b0, 1'b0, 3};
    tv[7]  = '{8'h3A, 8'h10, 8'h00, 1'b0, 1'b1, 1};
    tv[8]  = '{8'h27, 8'h08, 8'h19, 1'b0, 1'b0, 3};
    tv[9]  = '{8'hA0, 8'h00, 8'h00, 1'b0, 1'b1, 1};
    tv[10] = '{8'h05, 8'h93, 8'h88, 1'b1, 1'b0, 5};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_diff", 32'(ifc.diff), 32'd0);
    chk("rst_neg", 32'(ifc.neg), 32'd0);
    chk("rst_inv", 32'(ifc.invalid), 32'd0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    for (int i = 0; i < 11; i++) apply(tv[i]);

    // start re-pulsed during SUB1 must be ignored
    @(negedge clk);
    #1;
    ifc.a     = 8'h45;
    ifc.b     = 8'h12;
    ifc.start = 1'b1;
    push(8'h33, 1'b0, 1'b0, cyc + 3);
    @(negedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    #1;
    ifc.a     = 8'h99;
    ifc.b     = 8'h11;
    ifc.start = 1'b1;
    @(negedge clk);
    #1;
    ifc.start = 1'b0;
    wait_empty(12);
    repeat (6) @(negedge clk);
    #1;
    chk("ignored_start_diff", 32'(ifc.diff), 32'h33);

    // start held high through DONE: back-to-back accept
    @(negedge clk);
    #1;
    ifc.a     = 8'h12;
    ifc.b     = 8'h45;
    ifc.start = 1'b1;
    push(8'h33, 1'b1, 1'b0, cyc + 5);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (ifc.done) break;
    end
    ifc.a = 8'h30;
    ifc.b = 8'h01;
    push(8'h29, 1'b0, 1'b0, cyc + 3);
    @(negedge clk);
    #1;
    ifc.start = 1'b0;
    wait_empty(12);
    repeat (6) @(negedge clk);

    // reset during NEG0 aborts with no done
    @(negedge clk);
    #1;
    ifc.a     = 8'h12;
    ifc.b     = 8'h45;
    ifc.start = 1'b1;
    @(negedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("neg0_busy", 32'(ifc.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_done", 32'(ifc.done), 32'd0);
    chk("abort_diff", 32'(ifc.diff), 32'd0);
    chk("abort_neg", 32'(ifc.neg), 32'd0);
    chk("abort_inv", 32'(ifc.invalid), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    v = '{8'h27, 8'h08, 8'h19, 1'b0, 1'b0, 3};
    apply(v);
    v = '{8'h12, 8'h45, 8'h33, 1'b1, 1'b0, 5};
    apply(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_sub8.md
# bcd_sub8

Sequential two-digit (8-bit packed BCD) subtractor, the counterpart to the team's 8-bit BCD adder datapath. It computes A − B one decimal digit per cycle with a registered borrow. A negative raw result is converted to sign-magnitude by a second digit-serial ten's-complement pass. It sits beside the adder behind the same operand registers and feeds the same 7-segment result path, using a start/done handshake.

## Interface
- No parameters; the width is fixed at 2 BCD digits.
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when the block is ready to accept
- a  in  8  minuend, packed BCD {tens, units}
- b  in  8  subtrahend, packed BCD {tens, units}
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on
- diff  out  8  magnitude |A−B|, packed BCD
- neg  out  1  high when A < B
- invalid  out  1  an input nibble was greater than 9 when start was accepted

## Operation
- States: IDLE, SUB0, SUB1, NEG0, NEG1, DONE.
- Accept condition: start=1 in IDLE or DONE. On accept:
  - latch a and b into internal registers;
  - clear the borrow flop;
  - clear invalid and neg.
- Digit step, shared by all computing states:
  - t = x − y − bin, evaluated as a 5-bit signed value;
  - if t < 0: digit = t + 10 and bout = 1; otherwise digit = t and bout = 0.
- SUB0: x = a units, y = b units, bin = 0. Write raw units; store bout.
- SUB1: x = a tens, y = b tens, bin = stored borrow. Write raw tens; store bout.
- After SUB1:
  - borrow = 0: go to DONE with neg = 0 and diff = raw.
  - borrow = 1: go to NEG0.
- NEG0/NEG1 compute 0 − raw digit by digit, units then tens, with the borrow chained. The result is 100 − raw, which equals the true magnitude. Set neg = 1. The final borrow of this pass is ignored.
- Invalid input: if any of the four latched nibbles is greater than 9 on accept, go directly to DONE with invalid = 1, diff = 0x00, neg = 0.
- DONE lasts one cycle: done = 1, busy = 0, then return to IDLE. A start sampled in DONE is accepted in that cycle (back-to-back operation).
- diff, neg and invalid hold their values until the next accepted start, where they are cleared.
- A start while busy is ignored. Operands are not re-sampled mid-operation.
- Reset values:
  - state = IDLE, busy = 0, done = 0, diff = 0x00, neg = 0, invalid = 0, borrow = 0.
  - Reset mid-operation aborts immediately; no done pulse follows.

## Timing
- Start accepted at edge T:
  - busy = 1 from T+1; SUB0 at T+1, SUB1 at T+2.
  - Non-negative result: done at T+3.
  - Negative result: NEG0 at T+3, NEG1 at T+4, done at T+5.
  - Invalid input: done at T+1, busy never asserted.
- busy is high in SUB0, SUB1, NEG0 and NEG1 only.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back throughput: one operation every 3 cycles (non-negative results) or 5 cycles (negative results).

## Test plan
- a=0x45, b=0x12, start pulse at T → done at T+3; diff=0x33, neg=0, invalid=0. busy high only at T+1 and T+2.
- a=0x12, b=0x45 → done at T+5; diff=0x33, neg=1. Repeat with a=0x00, b=0x99 → diff=0x99, neg=1. Repeat with a=0x50, b=0x51 → diff=0x01, neg=1.
- Zero and boundary cases:
  - a=0x50, b=0x50 → diff=0x00, neg=0 at T+3.
  - a=0x99, b=0x00 → diff=0x99, neg=0.
  - a=0x30, b=0x01 (borrow across digits) → diff=0x29, neg=0.
- a=0x3A, b=0x10 → done at T+1; invalid=1, diff=0x00, neg=0, busy stays 0. The next valid op clears invalid.
- Start re-pulsed in SUB1 with new operands → ignored; first result unchanged. Start held high through DONE → second operation accepted in the DONE cycle, its done arrives 3 or 5 cycles later.
- rst asserted during NEG0 → next cycle state = IDLE, all outputs 0, no done pulse. A fresh op afterwards completes normally.
